detector_responder: RTL
=======================

Name: detector_responder

Overview:
- Synthesizable detector-side end of the trigger/ready handshake driven by fsm_experiment.
- Receives `output_trigger`, qualifies its pulse width, waits a programmable latency, then returns a `detector_ready` pulse.
- Used on the hardware-in-the-loop fixture board in place of a real detector, so fsm_experiment can be exercised on silicon, including its ready-timeout path.

Parameters:
- CNT_W, 32, width of all timing counters, config fields and event counters.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  responder armed when high; when low, state forced to IDLE synchronously.
- par  input  responder_params_t  runtime config: min_trig_len, ready_delay, ready_len (each CNT_W).
- output_trigger  input  1  asynchronous trigger from the sync block.
- clear_err  input  1  synchronous clear of overlap_err.
- detector_ready  output  1  ready pulse returned to the sync block.
- busy  output  1  high in any state other than IDLE.
- trig_count  output  CNT_W  accepted triggers; wraps at 2^CNT_W.
- glitch_count  output  CNT_W  rejected short pulses; saturates at all-ones.
- overlap_err  output  1  sticky flag: a trigger arrived while a response was in progress.

Behaviour:
- Reset (reset=0):
  - state=IDLE; all counters=0; detector_ready=0, busy=0, overlap_err=0.
  - Synchronizer flops are cleared.
- Input path:
  - output_trigger passes through a 2-FF synchronizer to give trig_s.
  - rise = trig_s & ~trig_s_d.
  - Raw-to-trig_s latency is 2 cycles.
- Effective config values: minl=max(par.min_trig_len,1) and rlen=max(par.ready_len,1).
- Config sampling: par is sampled on the acceptance cycle and held internally for that response. Changes mid-response take effect on the next trigger.
- States: IDLE, MEASURE, DELAY, READY, DEAD.
- IDLE:
  - Condition: enable=1 and trig_s=1.
  - If minl=1: accept now and go to DELAY.
  - Otherwise: width_cnt=1, go to MEASURE.
- MEASURE:
  - trig_s=1: width_cnt++.
  - When width_cnt+1==minl: accept and go to DELAY.
  - trig_s=0 before acceptance: glitch_count++ (saturating), go to IDLE.
- Acceptance cycle A:
  - trig_count++.
  - delay_cnt=0.
- DELAY: delay_cnt++ each cycle. Leave for READY on the cycle where delay_cnt==ready_delay, so ready_delay=0 gives one DELAY cycle.
- Ready timing: detector_ready is registered and high from cycle A+ready_delay+2 for exactly rlen cycles.
- READY: after rlen cycles, go to DEAD. detector_ready falls on the same edge.
- DEAD:
  - Wait for trig_s=0, then go to IDLE.
  - This enforces one response per trigger, even for a trigger held high indefinitely.
- Overlap:
  - rise while in DELAY, READY or DEAD sets overlap_err.
  - The new pulse is otherwise ignored: no count, and no extension of the current response.
- clear_err:
  - Clears overlap_err.
  - If a new overlap occurs in the same cycle, set wins.
- enable=0 mid-operation:
  - Next cycle: state=IDLE, detector_ready=0.
  - Counters hold; overlap_err holds.
  - On re-enable, a still-high trigger is treated as a new pulse only after it goes low. An armed flag is set only once trig_s=0 is seen in IDLE.
- Async reset mid-pulse: detector_ready drops immediately (asynchronous).
- Counter widths: width_cnt saturates at all-ones. Compares use CNT_W unsigned.

Optional Feature:
- Macro: RESP_FAULT_INJECT_EN.
- When defined:
  - Extra input drop_ready (1 bit) is present.
  - If drop_ready=1 on acceptance cycle A, the trigger is counted, the FSM goes directly to DEAD, and detector_ready never asserts.
  - Purpose: exercise fsm_experiment's DETECTOR_READY_TIMEOUT.
  - A second output, drop_count (CNT_W, wrapping), counts dropped responses.
- When undefined: neither port exists, and every accepted trigger gets a response.

Decomposition:
- types_pkg additions:
  - responder_params_t (packed struct: min_trig_len, ready_delay, ready_len).
  - resp_state_t enum (IDLE, MEASURE, DELAY, READY, DEAD).
  - RESP_CNT_W=32 constant.
- One sub-module, sync_edge:
  - 2-FF synchronizer plus rising-edge detector.
  - Async active-low reset.
  - Outputs: sync, rise.
  - Reused by other opto/sensor inputs.

Test Plan:
- Nominal: minl=20, ready_delay=200, rlen=100, 1000 ns trigger at 5 ns clock → detector_ready high 100 cycles, starting 202 cycles after trig_s rose past acceptance (A+202); trig_count=1.
- Glitch: 10-cycle pulse with minl=20 → no ready; glitch_count=1; trig_count=0; FSM back in IDLE the cycle after trig_s falls.
- Boundaries: ready_delay=0, ready_len=0, min_trig_len=0 → ready is 1 cycle wide at A+2, and acceptance happens on the first trig_s high cycle.
- Overlap and held trigger:
  - Second trigger during DELAY → overlap_err=1, trig_count stays 1.
  - Held trigger → a single response; IDLE only after the trigger falls.
  - clear_err → overlap_err=0.
- Mid-operation:
  - enable=0 during READY → detector_ready=0 next cycle.
  - reset=0 during READY → immediate clear of all outputs.
- With RESP_FAULT_INJECT_EN and drop_ready=1: trigger → no ready; trig_count=1; drop_count=1; FSM returns to IDLE after the trigger falls.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the detector-side responder of the trigger/ready handshake.
`timescale 1ns/1ps
package types_pkg;

    localparam int RESP_CNT_W = 32;

    typedef struct packed {
        logic [RESP_CNT_W-1:0] min_trig_len;
        logic [RESP_CNT_W-1:0] ready_delay;
        logic [RESP_CNT_W-1:0] ready_len;
    } responder_params_t;

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        DELAY,
        READY,
        DEAD
    } resp_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a rising-edge strobe on the synchronized level.
`timescale 1ns/1ps
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync = s2_q;
    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/detector_responder.sv
// Qualifies output_trigger width, waits ready_delay, returns a detector_ready pulse.
// Build with RESP_FAULT_INJECT_EN to add drop_ready / drop_count.
`timescale 1ns/1ps
module detector_responder
    import types_pkg::*;
#(
    parameter int CNT_W = RESP_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  responder_params_t par,
    input  logic              output_trigger,
    input  logic              clear_err,
    output logic              detector_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  trig_count,
    output logic [CNT_W-1:0]  glitch_count,
    output logic              overlap_err
`ifdef RESP_FAULT_INJECT_EN
    ,
    input  logic              drop_ready,
    output logic [CNT_W-1:0]  drop_count
`endif
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic trig_s;
    logic rise;

    sync_edge u_sync (
        .clock (clock),
        .reset (reset),
        .din   (output_trigger),
        .sync  (trig_s),
        .rise  (rise)
    );

    resp_state_t      state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] rlen_q, rlen_d;
    logic [CNT_W-1:0] trig_q, trig_d;
    logic [CNT_W-1:0] glitch_q, glitch_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             err_q, err_d;
    logic             rdy_q, rdy_d;
    logic             armed_q, armed_d;

    logic [CNT_W-1:0] minl;
    logic [CNT_W-1:0] rlen_in;
    logic             accept;
    logic             ovl;

    assign minl    = (CNT_W'(par.min_trig_len) == '0) ? ONE : CNT_W'(par.min_trig_len);
    assign rlen_in = (CNT_W'(par.ready_len) == '0) ? ONE : CNT_W'(par.ready_len);

    assign ovl = enable & rise &
                 ((state_q == DELAY) | (state_q == READY) | (state_q == DEAD));

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        rlen_d   = rlen_q;
        trig_d   = trig_q;
        glitch_d = glitch_q;
        drop_d   = drop_q;
        rdy_d    = rdy_q;
        armed_d  = armed_q;
        accept   = 1'b0;
        err_d    = (err_q & ~clear_err) | ovl;

        if (!enable) begin
            state_d = IDLE;
            rdy_d   = 1'b0;
            armed_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!trig_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        if (minl == ONE) begin
                            accept = 1'b1;
                        end else begin
                            width_d = ONE;
                            state_d = MEASURE;
                        end
                    end
                end
                MEASURE: begin
                    if (!trig_s) begin
                        if (glitch_q != '1) glitch_d = glitch_q + ONE;
                        state_d = IDLE;
                    end else if (width_q + ONE == minl) begin
                        accept = 1'b1;
                    end else if (width_q != '1) begin
                        width_d = width_q + ONE;
                    end
                end
                DELAY: begin
                    if (cnt_q == rd_q) begin
                        state_d = READY;
                        cnt_d   = ONE;
                        rdy_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                READY: begin
                    if (cnt_q == rlen_q) begin
                        state_d = DEAD;
                        rdy_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                DEAD: begin
                    if (!trig_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // Response timing is frozen at acceptance; later par edits wait for the next trigger.
            if (accept) begin
                trig_d  = trig_q + ONE;
                cnt_d   = '0;
                rd_d    = CNT_W'(par.ready_delay);
                rlen_d  = rlen_in;
                state_d = DELAY;
`ifdef RESP_FAULT_INJECT_EN
                if (drop_ready) begin
                    state_d = DEAD;
                    drop_d  = drop_q + ONE;
                end
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            width_q  <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            rlen_q   <= '0;
            trig_q   <= '0;
            glitch_q <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            rlen_q   <= rlen_d;
            trig_q   <= trig_d;
            glitch_q <= glitch_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            rdy_q    <= rdy_d;
            armed_q  <= armed_d;
        end
    end

    assign detector_ready = rdy_q;
    assign busy           = (state_q != IDLE);
    assign trig_count     = trig_q;
    assign glitch_count   = glitch_q;
    assign overlap_err    = err_q;
`ifdef RESP_FAULT_INJECT_EN
    assign drop_count     = drop_q;
`endif

endmodule
